// File: rtl/instr_issue.sv
// instr_issue -- fetch-side issue buffer and IF/ID pipeline register.
//
// Accepts instruction words from fetch over a valid/ready handshake into a
// 2-entry FIFO and presents one instruction per cycle to decode. Empty cycles
// become NOP bubbles, stall holds IF/ID, and flush squashes everything. Once a
// halt (opcode 0) reaches IF/ID, fetch is closed until a flush or reset.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   fetch_valid/_instr/_pc        word offered by fetch
//   fetch_ready                   buffer can take a word this cycle (registered state only)
//   stall                         hold IF/ID
//   flush                         squash FIFO and IF/ID (wins over stall)
//   instr, opcode, validIns, pc   IF/ID contents; validIns=0 marks a bubble
//   pc_plus2                      pc + 2 (mod 2^16)
//   halted                        halt issued, fetch closed
module instr_issue #(
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_valid,
   input  logic [15:0] fetch_instr,
   input  logic [15:0] fetch_pc,
   output logic        fetch_ready,
   input  logic        stall,
   input  logic        flush,
   output logic [15:0] instr,
   output logic [4:0]  opcode,
   output logic        validIns,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        halted
);

   typedef enum logic {RUN, HALT_SEEN} state_t;

   state_t      state;
   logic [1:0]  count;
   logic        head;
   logic        tail;
   logic [15:0] memInstr [2];
   logic [15:0] memPc    [2];

   logic        transfer;
   logic        advance;
   logic        pop;
   logic        bypass;
   logic        push;
   logic        loadValid;
   logic [15:0] loadInstr;
   logic [15:0] loadPc;
   logic        haltLoad;

   always_comb begin
      fetch_ready = (count < 2'd2) && (state == RUN);
      transfer    = fetch_valid && fetch_ready;
      advance     = !stall && !flush;
      pop         = advance && (count != 2'd0);
      // Empty FIFO: an incoming word goes straight to IF/ID without a FIFO write.
      bypass      = advance && (count == 2'd0) && transfer;
      push        = transfer && !bypass && !flush;
      loadValid   = pop || bypass;
      loadInstr   = pop ? memInstr[head] : fetch_instr;
      loadPc      = pop ? memPc[head]    : fetch_pc;
      haltLoad    = loadValid && (loadInstr[15:11] == 5'b0_0000) && (state == RUN);
   end

   assign opcode   = instr[15:11];
   assign pc_plus2 = pc + 16'd2;
   assign halted   = (state == HALT_SEEN);

   // Storage array carries no reset; occupancy is tracked by count/head/tail.
   always_ff @(posedge clk) begin
      if (push && !haltLoad) begin
         memInstr[tail] <= fetch_instr;
         memPc[tail]    <= fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         count    <= '0;
         head     <= 1'b0;
         tail     <= 1'b0;
         instr    <= NOP_INSTR;
         validIns <= 1'b0;
         pc       <= '0;
      end else if (flush) begin
         // Flush also revives a wrong-path halt; pc is held like any bubble.
         state    <= RUN;
         count    <= '0;
         head     <= 1'b0;
         tail     <= 1'b0;
         instr    <= NOP_INSTR;
         validIns <= 1'b0;
      end else begin
         if (advance) begin
            if (loadValid) begin
               instr    <= loadInstr;
               pc       <= loadPc;
               validIns <= 1'b1;
            end else begin
               instr    <= NOP_INSTR;
               validIns <= 1'b0;
            end
         end
         if (haltLoad) begin
            // Words queued behind a halt are dropped; fetch closes next cycle.
            state <= HALT_SEEN;
            count <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
         end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic [15:0] fetch_instr;
   logic [15:0] fetch_pc;
   logic        fetch_ready;
   logic        stall;
   logic        flush;
   logic [15:0] instr;
   logic [4:0]  opcode;
   logic        validIns;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        halted;

   int unsigned compared = 0;
   int unsigned mismatched = 0;

   instr_issue #(.NOP_INSTR(16'h0800)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
      .fetch_ready(fetch_ready), .stall(stall), .flush(flush),
      .instr(instr), .opcode(opcode), .validIns(validIns), .pc(pc),
      .pc_plus2(pc_plus2), .halted(halted)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [15:0] w, input logic [15:0] a);
      fetch_valid = v;
      fetch_instr = w;
      fetch_pc    = a;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      offer(1'b0, 16'h0, 16'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", validIns); end
      compared++; if (opcode !== 5'b0_0001) begin mismatched++; $display("FAIL reset_opcode: got %b want 00001", opcode); end
      compared++; if (instr !== 16'h0800) begin mismatched++; $display("FAIL reset_instr: got %h want 0800", instr); end
      compared++; if (fetch_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", fetch_ready); end
      compared++; if (pc !== 16'h0000) begin mismatched++; $display("FAIL reset_pc: got %h want 0000", pc); end
      compared++; if (pc_plus2 !== 16'h0002) begin mismatched++; $display("FAIL reset_pc2: got %h want 0002", pc_plus2); end
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b want 0", halted); end
   endtask

   task automatic test_stream();
      offer(1'b1, 16'h4000, 16'h0010);
      tick();
      compared++; if (validIns !== 1'b1) begin mismatched++; $display("FAIL stream_valid0: got %b want 1", validIns); end
      compared++; if (opcode !== 5'b0_1000) begin mismatched++; $display("FAIL stream_opcode0: got %b want 01000", opcode); end
      compared++; if (pc !== 16'h0010) begin mismatched++; $display("FAIL stream_pc0: got %h want 0010", pc); end
      offer(1'b1, 16'h4100, 16'h0012);
      tick();
      compared++; if (instr !== 16'h4100) begin mismatched++; $display("FAIL stream_instr1: got %h want 4100", instr); end
      compared++; if (pc !== 16'h0012) begin mismatched++; $display("FAIL stream_pc1: got %h want 0012", pc); end
      compared++; if (pc_plus2 !== 16'h0014) begin mismatched++; $display("FAIL stream_pc2: got %h want 0014", pc_plus2); end
      offer(1'b0, 16'h0, 16'h0);
      tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL stream_bubble: got %b want 0", validIns); end
      compared++; if (instr !== 16'h0800) begin mismatched++; $display("FAIL stream_nop: got %h want 0800", instr); end
      compared++; if (pc !== 16'h0012) begin mismatched++; $display("FAIL stream_pchold: got %h want 0012", pc); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      offer(1'b1, 16'h4201, 16'h0020);   // accepted into FIFO
      tick();
      offer(1'b1, 16'h4302, 16'h0022);   // accepted, FIFO now full
      tick();
      offer(1'b1, 16'h4403, 16'h0024);   // refused while full
      compared++; if (fetch_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ready_full: got %b want 0", fetch_ready); end
      tick(); tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL stall_hold: got %b want 0", validIns); end
      compared++; if (pc !== 16'h0012) begin mismatched++; $display("FAIL stall_hold_pc: got %h want 0012", pc); end
      stall = 1'b0;
      tick();                           // pops 4201; 4403 still not accepted
      compared++; if (instr !== 16'h4201 || pc !== 16'h0020) begin mismatched++; $display("FAIL stall_out0: got %h@%h want 4201@0020", instr, pc); end
      compared++; if (fetch_ready !== 1'b1) begin mismatched++; $display("FAIL stall_ready_free: got %b want 1", fetch_ready); end
      tick();                           // pops 4302, pushes 4403
      compared++; if (instr !== 16'h4302 || pc !== 16'h0022) begin mismatched++; $display("FAIL stall_out1: got %h@%h want 4302@0022", instr, pc); end
      offer(1'b0, 16'h0, 16'h0);
      tick();
      compared++; if (instr !== 16'h4403 || pc !== 16'h0024 || validIns !== 1'b1) begin mismatched++; $display("FAIL stall_out2: got %h@%h v%b want 4403@0024 v1", instr, pc, validIns); end
      tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL stall_drained: got %b want 0", validIns); end
   endtask

   task automatic test_flush();
      offer(1'b1, 16'h4500, 16'h0030);   // bypass into IF/ID
      tick();
      stall = 1'b1;
      offer(1'b1, 16'h4600, 16'h0032);   // queued behind stall
      tick();
      flush = 1'b1;
      offer(1'b1, 16'h4700, 16'h0034);   // transferred in flush cycle, discarded
      tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL flush_valid: got %b want 0", validIns); end
      compared++; if (instr !== 16'h0800) begin mismatched++; $display("FAIL flush_instr: got %h want 0800", instr); end
      compared++; if (fetch_ready !== 1'b1) begin mismatched++; $display("FAIL flush_ready: got %b want 1", fetch_ready); end
      flush = 1'b0; stall = 1'b0;
      offer(1'b1, 16'h4800, 16'h0040);
      tick();
      compared++; if (instr !== 16'h4800 || pc !== 16'h0040 || validIns !== 1'b1) begin mismatched++; $display("FAIL flush_next: got %h@%h v%b want 4800@0040 v1", instr, pc, validIns); end
      offer(1'b0, 16'h0, 16'h0);
      tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL flush_empty: got %b want 0", validIns); end
   endtask

   task automatic test_halt();
      offer(1'b1, 16'h0000, 16'h0050);
      tick();
      compared++; if (validIns !== 1'b1 || opcode !== 5'b0_0000) begin mismatched++; $display("FAIL halt_issue: got v%b op %b want v1 op 00000", validIns, opcode); end
      compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_halted: got %b want 1", halted); end
      compared++; if (fetch_ready !== 1'b0) begin mismatched++; $display("FAIL halt_ready: got %b want 0", fetch_ready); end
      offer(1'b1, 16'h4900, 16'h0052);   // must not be accepted
      tick();
      compared++; if (validIns !== 1'b0 || instr !== 16'h0800) begin mismatched++; $display("FAIL halt_bubble: got %h v%b want 0800 v0", instr, validIns); end
      tick();
      compared++; if (validIns !== 1'b0 || halted !== 1'b1) begin mismatched++; $display("FAIL halt_stays: got v%b h%b want v0 h1", validIns, halted); end
      offer(1'b0, 16'h0, 16'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL halt_flush_halted: got %b want 0", halted); end
      compared++; if (fetch_ready !== 1'b1) begin mismatched++; $display("FAIL halt_flush_ready: got %b want 1", fetch_ready); end
   endtask

   task automatic test_wrap_and_reset();
      offer(1'b1, 16'h4A00, 16'hFFFE);
      tick();
      compared++; if (pc !== 16'hFFFE) begin mismatched++; $display("FAIL wrap_pc: got %h want fffe", pc); end
      compared++; if (pc_plus2 !== 16'h0000) begin mismatched++; $display("FAIL wrap_pc2: got %h want 0000", pc_plus2); end
      stall = 1'b1;
      offer(1'b1, 16'h4B00, 16'h0060);   // queued, then lost to reset
      tick();
      offer(1'b0, 16'h0, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      compared++; if (validIns !== 1'b0 || instr !== 16'h0800) begin mismatched++; $display("FAIL async_rst_ifid: got %h v%b want 0800 v0", instr, validIns); end
      compared++; if (pc !== 16'h0000 || pc_plus2 !== 16'h0002) begin mismatched++; $display("FAIL async_rst_pc: got %h/%h want 0000/0002", pc, pc_plus2); end
      tick();
      rst_n = 1'b1; stall = 1'b0;
      tick();
      compared++; if (validIns !== 1'b0) begin mismatched++; $display("FAIL rst_dropped: got %b want 0", validIns); end
      compared++; if (fetch_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", fetch_ready); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_halt();
      test_wrap_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
